// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin share of one single-port BRAM
// among N_REQ requesters, with fixed-latency read-response routing.
module bram_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    bram_en,
  output logic                    bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DATA_W-1:0]       bram_wdata,
  input  logic [DATA_W-1:0]       bram_rdata
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gid;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] issue_id;
  logic [IDW:0]   idx;
  logic           any;
  logic           acc;

  logic [RD_LAT-1:0]          pv;
  logic [RD_LAT-1:0][IDW-1:0] pid;

  // First valid requester at or after rr_ptr, modulo N_REQ
  always_comb begin
    any = 1'b0;
    gid = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N_REQ))
        idx = idx - (IDW+1)'(N_REQ);
      if (!any && req_valid[idx[IDW-1:0]]) begin
        any = 1'b1;
        gid = idx[IDW-1:0];
      end
    end
  end

  assign acc = any & rst_n;

  always_comb begin
    req_ready = '0;
    if (acc)
      req_ready[gid] = 1'b1;
  end

  assign nxt_ptr = (gid == IDW'(N_REQ-1)) ? '0 : gid + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      issue_id   <= '0;
      pv         <= '0;
      pid        <= '0;
    end else begin
      bram_en <= acc;
      bram_we <= acc & req_we[gid];
      if (acc) begin
        rr_ptr     <= nxt_ptr;
        bram_addr  <= req_addr[int'(gid)*ADDR_W +: ADDR_W];
        bram_wdata <= req_wdata[int'(gid)*DATA_W +: DATA_W];
        issue_id   <= gid;
      end
      // Reads enter the tracker on their bram_en cycle
      pv[0]  <= bram_en & ~bram_we;
      pid[0] <= issue_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pv[RD_LAT-1])
      rsp_valid[pid[RD_LAT-1]] = 1'b1;
  end

  assign rsp_rdata = bram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: vector table, directed corner sequences
// and random traffic against a cycle-scheduled reference model.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 36;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, bram_wdata, bram_rdata;
  logic            bram_en, bram_we;
  logic [AW-1:0]   bram_addr;

  bram_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Read-first BRAM with RL-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rq [RL];
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    if (bram_en && !bram_we) rq[0] <= mem[bram_addr];
    for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
  end
  assign bram_rdata = rq[RL-1];

  // Reference: expectations scheduled by absolute cycle number
  int            cyc = 0;
  int            mptr = 0;
  int            g, s, s1, s2;
  logic [DW-1:0] smem [0:(1<<AW)-1];
  bit            e_en [64];
  bit            e_we [64];
  logic [AW-1:0] e_addr [64];
  logic [DW-1:0] e_wd [64];
  bit            r_v [64];
  int            r_id [64];
  logic [DW-1:0] r_d [64];
  logic [AW-1:0] m_addr, ga;
  logic [DW-1:0] m_wd, gd;
  logic [N-1:0]  er, ev;

  always @(negedge clk) begin
    s = cyc % 64;
    if (!rst_n) begin
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp", 64'(rsp_valid), 64'(0));
      chk("rst_en_we", 64'({bram_en, bram_we}), 64'(0));
      chk("rst_addr", 64'(bram_addr), 64'(0));
      chk("rst_wdata", 64'(bram_wdata), 64'(0));
      mptr = 0;
      m_addr = '0;
      m_wd = '0;
      for (int i = 0; i < 64; i++) begin
        e_en[i] = 0;
        r_v[i] = 0;
      end
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr+k)%N]) g = (mptr + k) % N;
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("ready", 64'(req_ready), 64'(er));
      if (e_en[s]) begin
        m_addr = e_addr[s];
        m_wd = e_wd[s];
      end
      chk("bram_en", 64'(bram_en), 64'(e_en[s]));
      chk("bram_we", 64'(bram_we), 64'(e_en[s] && e_we[s]));
      chk("bram_addr", 64'(bram_addr), 64'(m_addr));
      chk("bram_wdata", 64'(bram_wdata), 64'(m_wd));
      ev = r_v[s] ? (N'(1) << r_id[s]) : '0;
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (r_v[s]) chk("rsp_rdata", 64'(rsp_rdata), 64'(r_d[s]));
      e_en[s] = 0;
      r_v[s] = 0;
      if (g >= 0) begin
        ga = req_addr[g*AW +: AW];
        gd = req_wdata[g*DW +: DW];
        s1 = (cyc + 1) % 64;
        e_en[s1] = 1;
        e_we[s1] = req_we[g];
        e_addr[s1] = ga;
        e_wd[s1] = gd;
        if (req_we[g]) smem[ga] = gd;
        else begin
          s2 = (cyc + 1 + RL) % 64;
          r_v[s2] = 1;
          r_id[s2] = g;
          r_d[s2] = smem[ga];
        end
        mptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rdy;
    logic         en;
  } vec_t;
  vec_t tbl [16];

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] acc;

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'hF, N'(1) << (i % 4), (i != 0)};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0001, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 1'b1};
    tbl[11] = '{4'b1001, 4'b0001, 1'b1};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1};
    tbl[13] = '{4'b0011, 4'b0001, 1'b1};
    tbl[14] = '{4'b0011, 4'b0010, 1'b1};
    tbl[15] = '{4'b1010, 4'b1000, 1'b1};
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i] = '0;
      smem[i] = '0;
    end
    for (int i = 0; i < RL; i++) rq[i] = '0;

    // Reset with every requester asking
    req_valid = '1;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'(4'b0001));
    step();
    clr();
    @(negedge clk);
    chk("first_en", 64'(bram_en), 64'(1));
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Fairness and pointer-skip vectors from rr_ptr = 0
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].v;
      req_we = '1;
      for (int j = 0; j < N; j++) begin
        req_addr[j*AW +: AW] = AW'(100 + i*4 + j);
        req_wdata[j*DW +: DW] = DW'({$urandom, $urandom});
      end
      @(negedge clk);
      chk("tbl_ready", 64'(req_ready), 64'(tbl[i].rdy));
      chk("tbl_en", 64'(bram_en), 64'(tbl[i].en));
      step();
    end
    clr();
    step();

    // Single requester streaming writes
    for (int k = 0; k < 6; k++) begin
      set_req(2, 1'b1, 1'b1, AW'(k), 36'hA0000000 + DW'(k));
      @(negedge clk);
      chk("stream_ready", 64'(req_ready), 64'(4'b0100));
      step();
    end
    clr();
    repeat (4) step();

    // Read routing back to issuing requesters
    set_req(0, 1'b1, 1'b1, AW'(5), 36'h123456789);
    step();
    clr();
    set_req(0, 1'b1, 1'b1, AW'(6), 36'hFEDCBA987);
    step();
    clr();
    repeat (3) step();
    set_req(1, 1'b1, 1'b0, AW'(5), '0);
    @(negedge clk);
    chk("rd1_ready", 64'(req_ready), 64'(4'b0010));
    step();
    clr();
    set_req(3, 1'b1, 1'b0, AW'(6), '0);
    @(negedge clk);
    chk("rd3_ready", 64'(req_ready), 64'(4'b1000));
    step();
    clr();
    @(negedge clk);
    chk("rd_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("rd1_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("rd1_data", 64'(rsp_rdata), 64'(36'h123456789));
    @(negedge clk);
    chk("rd3_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("rd3_data", 64'(rsp_rdata), 64'(36'hFEDCBA987));
    step();

    // Reset while a read is in flight
    set_req(1, 1'b1, 1'b0, AW'(5), '0);
    @(negedge clk);
    chk("mf_ready", 64'(req_ready), 64'(4'b0010));
    step();
    clr();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mf_no_rsp", 64'(rsp_valid), 64'(0));
    end
    step();
    req_valid = '1;
    req_we = '1;
    @(negedge clk);
    chk("mf_ptr0", 64'(req_ready), 64'(4'b0001));
    step();
    clr();
    step();

    // Random traffic; valid held until accepted
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      step();
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && !acc[i]))
          set_req(i, ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)),
                  DW'({$urandom, $urandom}));
        else if ($urandom_range(0, 3) == 0)
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
    end
    clr();
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
